amba_ahb_slave: RTL and testbench



---
 rtl/amba_ahb_slave.sv | 141 ++++++++++++++
 tb/tb_amba_ahb_slave.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/amba_ahb_slave.sv
// AHB-Lite single-port memory slave: 32-bit word store with byte, halfword
// and word access, zero-wait-state reads and writes, and a two-cycle ERROR
// response for illegal transfers. The `error` output mirrors `hresp`.
module amba_ahb_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,   // only 32 is supported
  parameter int MEM_DEPTH  = 256   // number of 32-bit words
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [3:0]            hprot,
  input  logic [DATA_WIDTH-1:0] hwdata,
  output logic [DATA_WIDTH-1:0] hrdata,
  output logic                  hready,
  output logic                  hresp,
  output logic                  error
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_LIMIT = ADDR_WIDTH'(MEM_DEPTH);

  typedef enum logic [1:0] {
    ST_OKAY = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } resp_state_e;

  resp_state_e state_q, state_d;

  // Registered address-phase information for the transfer in its data phase.
  // dp_valid_q is set only for legal transfers, so illegal ones never reach
  // the memory or the read mux.
  logic             dp_valid_q, dp_valid_d;
  logic             dp_write_q, dp_write_d;
  logic [IDX_W-1:0] dp_idx_q,   dp_idx_d;
  logic [1:0]       dp_ofs_q,   dp_ofs_d;
  logic [1:0]       dp_size_q,  dp_size_d;

  logic [31:0] mem_q [0:MEM_DEPTH-1];

  logic       accept;
  logic       size_ok;
  logic       align_ok;
  logic       range_ok;
  logic       legal;
  logic [3:0] byte_en;

  // Burst type, protection and the BUSY/IDLE distinction do not affect
  // behaviour; fold them into one sink so the intent is explicit.
  logic unused_bus_sigs;
  assign unused_bus_sigs = ^{hburst, hprot, htrans[0]};

  // Single-slave system: our own hready is the bus HREADY.
  assign hready = (state_q != ST_ERR1);
  assign hresp  = (state_q != ST_OKAY);
  assign error  = hresp;

  // NONSEQ and SEQ both have htrans[1] set; IDLE and BUSY do not.
  assign accept = hsel && hready && htrans[1];

  assign size_ok  = (hsize <= 3'd2);
  assign range_ok = ({2'b00, haddr[ADDR_WIDTH-1:2]} < DEPTH_LIMIT);
  assign legal    = size_ok && align_ok && range_ok;

  // Alignment rule depends on the transfer size.
  always_comb begin
    align_ok = 1'b1;
    case (hsize)
      3'd1:    align_ok = ~haddr[0];
      3'd2:    align_ok = (haddr[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase
  end

  // Next-state logic for the response FSM and the data-phase capture.
  always_comb begin
    state_d    = state_q;
    dp_valid_d = accept && legal;
    dp_write_d = hwrite;
    dp_idx_d   = haddr[IDX_W+1:2];
    dp_ofs_d   = haddr[1:0];
    dp_size_d  = hsize[1:0];
    case (state_q)
      ST_OKAY: if (accept && !legal) state_d = ST_ERR1;
      ST_ERR1: state_d = ST_ERR2;
      ST_ERR2: state_d = (accept && !legal) ? ST_ERR1 : ST_OKAY;
      default: state_d = ST_OKAY;
    endcase
  end

  // Response state and data-phase registers; reset drops any pending access.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q    <= ST_OKAY;
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_idx_q   <= '0;
      dp_ofs_q   <= 2'b00;
      dp_size_q  <= 2'b00;
    end else begin
      state_q    <= state_d;
      dp_valid_q <= dp_valid_d;
      dp_write_q <= dp_write_d;
      dp_idx_q   <= dp_idx_d;
      dp_ofs_q   <= dp_ofs_d;
      dp_size_q  <= dp_size_d;
    end
  end

  // Little-endian byte-lane enables for the data-phase transfer.
  always_comb begin
    byte_en = 4'b0000;
    case (dp_size_q)
      2'd0:    byte_en = 4'b0001 << dp_ofs_q;
      2'd1:    byte_en = dp_ofs_q[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  end

  // Memory write at the edge ending the write data phase; contents are not
  // reset, so this block has no reset term.
  always_ff @(posedge hclk) begin
    if (dp_valid_q && dp_write_q) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) begin
          mem_q[dp_idx_q][8*i +: 8] <= hwdata[8*i +: 8];
        end
      end
    end
  end

  // Full addressed word during a legal read data phase, zero otherwise.
  assign hrdata = (dp_valid_q && !dp_write_q) ? mem_q[dp_idx_q] : '0;

endmodule

// File: tb/tb_amba_ahb_slave.sv
// Bench for amba_ahb_slave: directed scenarios plus random traffic checked
// against a byte-addressed reference memory and an error-cycle counter.
module tb_amba_ahb_slave;

  localparam int MEM_DEPTH = 256;
  localparam int NBYTES    = 4 * MEM_DEPTH;
  localparam logic [1:0] T_IDLE = 2'd0, T_NSEQ = 2'd2, T_SEQ = 2'd3;

  logic        hclk;
  logic        hresetn;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;
  logic        error;

  amba_ahb_slave #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .MEM_DEPTH (MEM_DEPTH)
  ) dut (
    .hclk   (hclk),
    .hresetn(hresetn),
    .hsel   (hsel),
    .haddr  (haddr),
    .htrans (htrans),
    .hwrite (hwrite),
    .hsize  (hsize),
    .hburst (hburst),
    .hprot  (hprot),
    .hwdata (hwdata),
    .hrdata (hrdata),
    .hready (hready),
    .hresp  (hresp),
    .error  (error)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference state: byte memory, cycles into an error response
  // (0 none, 1 first, 2 second) and the transfer owning the data phase.
  logic [7:0]  ref_mem [0:NBYTES-1];
  int          err_phase = 0;
  bit          pend_v = 0;
  bit          pend_w = 0;
  int unsigned pend_a = 0;
  int          pend_sz = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int unsigned a);
    int unsigned b;
    b = a - (a % 4);
    return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
  endfunction

  function automatic bit is_legal(input logic [31:0] a, input logic [2:0] sz);
    if (sz > 3'd2) return 1'b0;
    if ((a % (32'd1 << sz)) != 0) return 1'b0;
    if (a >= 32'(NBYTES)) return 1'b0;
    return 1'b1;
  endfunction

  // One bus cycle: drive address phase + data-phase write data, advance the
  // reference, then compare all outputs shortly after the clock edge.
  task automatic bus_cycle(input logic sel, input logic [1:0] trans, input logic wr,
                           input logic [31:0] addr, input logic [2:0] sz,
                           input logic [31:0] wdata);
    bit          exp_ready;
    bit          acc;
    bit          lg;
    logic [31:0] exp_rd;
    hsel   = sel;
    htrans = trans;
    hwrite = wr;
    haddr  = addr;
    hsize  = sz;
    hwdata = wdata;
    hburst = 3'($urandom);
    hprot  = 4'($urandom);
    exp_ready = (err_phase != 1);
    if (pend_v && pend_w) begin
      for (int k = 0; k < (1 << pend_sz); k++) begin
        ref_mem[pend_a + k] = wdata[8*((pend_a + k) % 4) +: 8];
      end
    end
    acc = sel && exp_ready && trans[1];
    lg  = is_legal(addr, sz);
    if (acc && !lg)          err_phase = 1;
    else if (err_phase == 1) err_phase = 2;
    else                     err_phase = 0;
    pend_v  = acc && lg;
    pend_w  = wr;
    pend_a  = addr;
    pend_sz = int'(sz);
    if (acc) $display("xfer %s addr=%h size=%0d %s", wr ? "WR" : "RD", addr, sz, lg ? "okay" : "error");
    @(posedge hclk);
    #1;
    exp_rd = (pend_v && !pend_w) ? ref_word(pend_a) : 32'h0;
    chk("hready", {31'b0, hready}, {31'b0, (err_phase != 1)});
    chk("hresp",  {31'b0, hresp},  {31'b0, (err_phase != 0)});
    chk("error",  {31'b0, error},  {31'b0, (err_phase != 0)});
    chk("hrdata", hrdata, exp_rd);
  endtask

  task automatic idle_cycle();
    bus_cycle(1'b0, T_IDLE, 1'b0, 32'h0, 3'd0, $urandom);
  endtask

  // Illegal access, an ignored access during ERR1, then recovery.
  task automatic err_seq(input string tag, input logic [31:0] addr, input logic [2:0] sz);
    bus_cycle(1'b1, T_NSEQ, 1'b1, addr, sz, $urandom);
    chk({tag, "_err1_rdy"},  {31'b0, hready}, 32'd0);
    chk({tag, "_err1_resp"}, {31'b0, hresp},  32'd1);
    chk({tag, "_err1_flag"}, {31'b0, error},  32'd1);
    bus_cycle(1'b1, T_NSEQ, 1'b1, 32'h10, 3'd2, $urandom);
    chk({tag, "_err2_rdy"},  {31'b0, hready}, 32'd1);
    chk({tag, "_err2_resp"}, {31'b0, hresp},  32'd1);
    chk({tag, "_err2_flag"}, {31'b0, error},  32'd1);
    idle_cycle();
    chk({tag, "_ok_resp"}, {31'b0, hresp}, 32'd0);
    bus_cycle(1'b1, T_NSEQ, 1'b0, 32'h10, 3'd2, $urandom);
    chk({tag, "_readback"}, hrdata, 32'h1234_55EF);
    idle_cycle();
  endtask

  // Asynchronous reset pulse in the middle of a cycle.
  task automatic mid_reset();
    hsel   = 1'b0;
    htrans = T_IDLE;
    #2 hresetn = 1'b0;
    #1;
    chk("rst_hready", {31'b0, hready}, 32'd1);
    chk("rst_hresp",  {31'b0, hresp},  32'd0);
    chk("rst_error",  {31'b0, error},  32'd0);
    chk("rst_hrdata", hrdata, 32'd0);
    err_phase = 0;
    pend_v    = 1'b0;
    @(posedge hclk);
    @(negedge hclk);
    hresetn = 1'b1;
  endtask

  initial begin
    logic [31:0] a;
    logic [2:0]  sz;
    int          r;
    hresetn = 1'b0;
    hsel = 1'b0; haddr = '0; htrans = T_IDLE; hwrite = 1'b0;
    hsize = 3'd0; hburst = 3'd0; hprot = 4'd0; hwdata = '0;
    repeat (3) @(posedge hclk);
    #1;
    chk("reset_hready", {31'b0, hready}, 32'd1);
    chk("reset_hresp",  {31'b0, hresp},  32'd0);
    chk("reset_error",  {31'b0, error},  32'd0);
    chk("reset_hrdata", hrdata, 32'd0);
    @(negedge hclk);
    hresetn = 1'b1;
    #1;
    chk("post_reset_hready", {31'b0, hready}, 32'd1);
    chk("post_reset_hrdata", hrdata, 32'd0);

    // Fill the whole memory with known random words.
    for (int i = 0; i <= MEM_DEPTH; i++) begin
      bus_cycle(i < MEM_DEPTH, (i < MEM_DEPTH) ? T_NSEQ : T_IDLE, 1'b1,
                32'(4 * (i % MEM_DEPTH)), 3'd2, $urandom);
    end

    // Word write then immediate read.
    bus_cycle(1'b1, T_NSEQ, 1'b1, 32'h10, 3'd2, $urandom);
    bus_cycle(1'b1, T_NSEQ, 1'b0, 32'h10, 3'd2, 32'hDEAD_BEEF);
    chk("word_rd", hrdata, 32'hDEAD_BEEF);
    chk("word_rd_rdy", {31'b0, hready}, 32'd1);
    // Byte write into lane 1; other lanes of hwdata are junk.
    bus_cycle(1'b1, T_NSEQ, 1'b1, 32'h11, 3'd0, $urandom);
    bus_cycle(1'b1, T_NSEQ, 1'b0, 32'h10, 3'd2, 32'hA5A5_55A5);
    chk("byte_rd", hrdata, 32'hDEAD_55EF);
    // Halfword write into lanes 3,2.
    bus_cycle(1'b1, T_NSEQ, 1'b1, 32'h12, 3'd1, $urandom);
    bus_cycle(1'b1, T_NSEQ, 1'b0, 32'h10, 3'd2, 32'h1234_9999);
    chk("half_rd", hrdata, 32'h1234_55EF);
    idle_cycle();

    // INCR4 writes of 1..4 at 0x20..0x2C, then reads straight after.
    for (int i = 0; i <= 8; i++) begin
      bus_cycle(i < 8, (i == 8) ? T_IDLE : ((i % 4 == 0) ? T_NSEQ : T_SEQ),
                i < 4, 32'h20 + 32'(4 * (i % 4)), 3'd2,
                (i >= 1 && i <= 4) ? 32'(i) : $urandom);
      chk("burst_rdy", {31'b0, hready}, 32'd1);
      if (i >= 4 && i <= 7) chk("burst_rd", hrdata, 32'(i - 3));
    end

    err_seq("misalign_402", 32'h402, 3'd2);
    err_seq("range_400",    32'h400, 3'd2);
    err_seq("size3",        32'h10,  3'd3);
    err_seq("misalign_12",  32'h12,  3'd2);
    err_seq("half_odd",     32'h11,  3'd1);

    // Illegal transfer accepted in ERR2 goes straight back to ERR1.
    bus_cycle(1'b1, T_NSEQ, 1'b0, 32'h401, 3'd0, $urandom);
    bus_cycle(1'b1, T_NSEQ, 1'b0, 32'h10, 3'd2, $urandom);
    bus_cycle(1'b1, T_NSEQ, 1'b1, 32'h13, 3'd2, $urandom);
    chk("err2_to_err1_rdy", {31'b0, hready}, 32'd0);
    idle_cycle();
    chk("err2_to_err1_err2", {31'b0, hresp}, 32'd1);
    // Legal read accepted in ERR2 completes normally.
    bus_cycle(1'b1, T_NSEQ, 1'b0, 32'h10, 3'd2, $urandom);
    chk("err2_legal_rd", hrdata, 32'h1234_55EF);
    chk("err2_legal_resp", {31'b0, hresp}, 32'd0);
    idle_cycle();

    // Reset during a read data phase, then during a write data phase.
    bus_cycle(1'b1, T_NSEQ, 1'b0, 32'h10, 3'd2, $urandom);
    mid_reset();
    bus_cycle(1'b1, T_NSEQ, 1'b1, 32'h10, 3'd2, $urandom);
    hwdata = 32'hAAAA_AAAA;
    mid_reset();
    bus_cycle(1'b1, T_NSEQ, 1'b0, 32'h10, 3'd2, $urandom);
    chk("rst_discard_wr", hrdata, 32'h1234_55EF);
    idle_cycle();

    // Random traffic.
    for (int n = 0; n < 500; n++) begin
      sz = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      r  = int'($urandom_range(0, 19));
      if (r == 0)      a = $urandom;
      else if (r == 1) a = 32'(NBYTES + int'($urandom_range(0, 255)));
      else begin
        a = 32'($urandom_range(0, NBYTES - 1));
        if (sz <= 3'd2 && $urandom_range(0, 4) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      end
      bus_cycle($urandom_range(0, 9) != 0, 2'($urandom), 1'($urandom), a, sz, $urandom);
    end
    idle_cycle();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
